// File: rtl/lsu_mem_adapter_if.sv
// lsu_mem_adapter_if -- bundles the request/response handshake and the
// word-wide memory port of lsu_mem_adapter.
//
// Signals
//   req_valid/req_ready    : access request handshake
//   req_store, req_funct3  : store/load select and RV32I width/sign code
//   req_addr, req_wdata    : byte address and right-aligned store data
//   rsp_valid              : one-cycle completion pulse
//   rsp_rdata, rsp_fault   : extended load result / rejection flag
//   mem_read, mem_write    : memory-port strobes
//   mem_address, mem_wmask : word-aligned address and byte write mask
//   mem_wdata              : lane-aligned write data
//   mem_resp, mem_rdata    : memory acknowledge and read data
//
// Modports
//   slave  : the adapter itself
//   master : the surrounding pipeline plus memory model (environment side)
interface lsu_mem_adapter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  mem_resp, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_read, mem_write, mem_wmask, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output mem_resp, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter -- turns one RV32I load/store request into one or two
// word-aligned beats on a 32-bit memory port and returns the extended
// load result as a single-cycle response.
//
// Ports
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_mem_adapter_if.slave (request, response and memory signals)
//
// Configuration macro
//   MISALIGNED_SPLIT_EN : when defined, misaligned accesses are performed,
//                         using a second beat when they cross a word
//                         boundary; when undefined they fault and the
//                         second beat is never used.
module lsu_mem_adapter (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_adapter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;

  // Captured request; mask/data are stored already shifted into an 8-byte window
  logic        store_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic [29:0] word_r;
  logic        split_r;
  logic [7:0]  mask_r;
  logic [63:0] wdata_r;
  logic [63:0] buf_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_fault_r;

  logic        accept_s;
  logic        legal_s;
  logic        fault_s;
  logic        split_s;
  logic [2:0]  size_s;
  logic [3:0]  bytemask_s;
  logic [1:0]  off_s;
  logic [7:0]  mask64_s;
  logic [63:0] wdata64_s;
  logic [63:0] buf_s;
  logic [63:0] shifted_s;
  logic [31:0] result_s;

  // Truncate to the access width and sign- or zero-extend per funct3
  function automatic logic [31:0] extend_load(input logic [2:0] funct3,
                                              input logic [31:0] raw);
    logic [31:0] res;
    res = 32'h0000_0000;
    case (funct3)
      3'b000:  res = {{24{raw[7]}}, raw[7:0]};
      3'b001:  res = {{16{raw[15]}}, raw[15:0]};
      3'b010:  res = raw;
      3'b100:  res = {24'h00_0000, raw[7:0]};
      3'b101:  res = {16'h0000, raw[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  assign accept_s = bus.req_valid && (state_r == IDLE);
  assign off_s    = bus.req_addr[1:0];

  // Request decode: size, byte mask and funct3 legality
  always_comb begin
    size_s     = 3'd0;
    bytemask_s = 4'b0000;
    legal_s    = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00: begin
        size_s     = 3'd1;
        bytemask_s = 4'b0001;
      end
      2'b01: begin
        size_s     = 3'd2;
        bytemask_s = 4'b0011;
      end
      2'b10: begin
        size_s     = 3'd4;
        bytemask_s = 4'b1111;
      end
      default: begin
        size_s     = 3'd0;
        bytemask_s = 4'b0000;
      end
    endcase
    if (bus.req_store) begin
      legal_s = (bus.req_funct3[2] == 1'b0) && (bus.req_funct3[1:0] != 2'b11);
    end else begin
      legal_s = (bus.req_funct3 != 3'b011) && (bus.req_funct3 != 3'b110) &&
                (bus.req_funct3 != 3'b111);
    end
  end

`ifdef MISALIGNED_SPLIT_EN
  // A second beat is needed whenever the access runs past the word end
  assign split_s = (({1'b0, off_s} + size_s) > 3'd4);
  assign fault_s = !legal_s;
`else
  logic misaligned_s;

  // Offset must be a multiple of the access size
  always_comb begin
    misaligned_s = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   misaligned_s = off_s[0];
      2'b10:   misaligned_s = |off_s;
      default: misaligned_s = 1'b0;
    endcase
  end

  // Aligned accesses never cross a word, so the second beat is unreachable
  assign split_s = 1'b0;
  assign fault_s = !legal_s || misaligned_s;
`endif

  // Loads carry a zero mask so mem_wmask stays 0 on read beats
  assign mask64_s  = {4'b0000, bytemask_s & {4{bus.req_store}}} << off_s;
  assign wdata64_s = {32'h0000_0000, bus.req_wdata} << {off_s, 3'b000};

  // Read buffer as it will be after this cycle's memory acknowledge
  always_comb begin
    buf_s = buf_r;
    if (bus.mem_resp && (state_r == BEAT0)) begin
      buf_s = {buf_r[63:32], bus.mem_rdata};
    end else if (bus.mem_resp && (state_r == BEAT1)) begin
      buf_s = {bus.mem_rdata, buf_r[31:0]};
    end else begin
      buf_s = buf_r;
    end
  end

  assign shifted_s = buf_s >> {off_r, 3'b000};
  assign result_s  = store_r ? 32'h0000_0000 : extend_load(funct3_r, shifted_s[31:0]);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = fault_s ? DONE : BEAT0;
        end else begin
          state_s = IDLE;
        end
      end
      BEAT0: begin
        if (bus.mem_resp) begin
          state_s = split_r ? BEAT1 : DONE;
        end else begin
          state_s = BEAT0;
        end
      end
      BEAT1: begin
        if (bus.mem_resp) begin
          state_s = DONE;
        end else begin
          state_s = BEAT1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, read buffer and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r     <= 1'b0;
      funct3_r    <= 3'd0;
      off_r       <= 2'd0;
      word_r      <= 30'd0;
      split_r     <= 1'b0;
      mask_r      <= 8'h00;
      wdata_r     <= 64'h0;
      buf_r       <= 64'h0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_fault_r <= 1'b0;
    end else begin
      if (accept_s) begin
        store_r  <= bus.req_store;
        funct3_r <= bus.req_funct3;
        off_r    <= off_s;
        word_r   <= bus.req_addr[31:2];
        split_r  <= split_s;
        mask_r   <= mask64_s;
        wdata_r  <= wdata64_s;
      end
      buf_r <= buf_s;
      // Response registers change only on entry to DONE and hold otherwise
      if ((state_s == DONE) && (state_r != DONE)) begin
        rsp_fault_r <= (state_r == IDLE);
        rsp_rdata_r <= (state_r == IDLE) ? 32'h0000_0000 : result_s;
      end
    end
  end

  // Memory-port drive: decoded from registered state and captured request only
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = 32'h0000_0000;
    bus.mem_wmask   = 4'b0000;
    bus.mem_wdata   = 32'h0000_0000;
    case (state_r)
      BEAT0: begin
        bus.mem_read    = !store_r;
        bus.mem_write   = store_r;
        bus.mem_address = {word_r, 2'b00};
        bus.mem_wmask   = mask_r[3:0];
        bus.mem_wdata   = wdata_r[31:0];
      end
      BEAT1: begin
        bus.mem_read    = !store_r;
        bus.mem_write   = store_r;
        bus.mem_address = {word_r + 30'd1, 2'b00};
        bus.mem_wmask   = mask_r[7:4];
        bus.mem_wdata   = wdata_r[63:32];
      end
      default: begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = 32'h0000_0000;
        bus.mem_wmask   = 4'b0000;
        bus.mem_wdata   = 32'h0000_0000;
      end
    endcase
  end

  assign bus.req_ready = (state_r == IDLE);
  assign bus.rsp_valid = (state_r == DONE);
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_fault = rsp_fault_r;

endmodule
